// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state type and width helpers for the serial deserializer
package serial_pkg;

  // Receiver FSM states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Gap counter width: must hold 0..TIMEOUT, never narrower than one bit
  function automatic int timeout_cw(input int timeout_cycles);
    int w;
    w = clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/word_holding_reg.sv
// rtl/word_holding_reg.sv - one-word valid/ready output register with sticky overrun
module word_holding_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             xfer;
  logic             blocked;

  // Next-state: a transfer frees the slot in the same edge a new word may load,
  // so a word completing during a transfer is accepted without overrun
  always_comb begin
    xfer      = valid_q && out_ready;
    blocked   = valid_q && !out_ready;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (xfer) begin
      valid_d = 1'b0;
    end
    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    if (load) begin
      if (blocked) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = load_data;
        valid_d = 1'b1;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - framed serial-to-parallel receiver with timeout and overrun flags
module serial_deserializer
  import serial_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int MSB_FIRST = 0,
  parameter  int TIMEOUT   = 255,
  localparam int CW        = clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             serial_input,
  input  logic             bit_strobe,
  input  logic             frame_start,
  input  logic             out_ready,
  input  logic             clear_overrun,
  output logic [WIDTH-1:0] parallel_output,
  output logic             out_valid,
  output logic             busy,
  output logic [CW-1:0]    bit_count,
  output logic             frame_error,
  output logic             overrun
);

  localparam int               CW_T     = timeout_cw(TIMEOUT);
  localparam logic [CW-1:0]    LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW_T-1:0]  GAP_LAST = (TIMEOUT == 0) ? '0 : CW_T'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW_T-1:0]  gap_q, gap_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             timeout_hit;

  // Shift register contents after taking in the current serial bit
  always_comb begin
    if (MSB_FIRST != 0) begin
      shifted = {shreg_q[WIDTH-2:0], serial_input};
    end else begin
      shifted = {serial_input, shreg_q[WIDTH-1:1]};
    end
  end

  // FSM next-state: frame_start beats a strobe, a strobe beats the timeout
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    ferr_d      = 1'b0;
    word_done   = 1'b0;
    timeout_hit = (TIMEOUT != 0) && (gap_q == GAP_LAST);
    if (state_q == ST_IDLE) begin
      if (frame_start) begin
        state_d = ST_RECV;
        shreg_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end
    end else begin
      if (frame_start) begin
        shreg_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
        ferr_d  = 1'b1;
      end else if (bit_strobe) begin
        shreg_d = shifted;
        gap_d   = '0;
        if (cnt_q == LAST_BIT) begin
          word_done = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (timeout_hit) begin
        ferr_d  = 1'b1;
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
      end else if (TIMEOUT != 0) begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  // FSM, shift register and counters with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ferr_q  <= ferr_d;
    end
  end

  // The completed word (including the final bit) loads on the final strobe's edge
  word_holding_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .CLK           (CLK),
    .RST           (RST),
    .load          (word_done),
    .load_data     (shifted),
    .out_ready     (out_ready),
    .clear_overrun (clear_overrun),
    .data          (parallel_output),
    .valid         (out_valid),
    .overrun       (overrun)
  );

  assign busy        = (state_q == ST_RECV);
  assign bit_count   = cnt_q;
  assign frame_error = ferr_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - scoreboard bench for serial_deserializer (LSB- and MSB-first)
module tb_serial_deserializer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       serial_input;
  logic       bit_strobe;
  logic       frame_start;
  logic       out_ready;
  logic       clear_overrun;
  logic [7:0] po0, po1;
  logic       ov0, ov1, bz0, bz1, fe0, fe1, or0, or1;
  logic [3:0] bc0, bc1;

  always #5 CLK = ~CLK;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(0), .TIMEOUT(4)) dut0 (
    .CLK(CLK), .RST(RST), .serial_input(serial_input), .bit_strobe(bit_strobe),
    .frame_start(frame_start), .out_ready(out_ready), .clear_overrun(clear_overrun),
    .parallel_output(po0), .out_valid(ov0), .busy(bz0), .bit_count(bc0),
    .frame_error(fe0), .overrun(or0)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1), .TIMEOUT(4)) dut1 (
    .CLK(CLK), .RST(RST), .serial_input(serial_input), .bit_strobe(bit_strobe),
    .frame_start(frame_start), .out_ready(out_ready), .clear_overrun(clear_overrun),
    .parallel_output(po1), .out_valid(ov1), .busy(bz1), .bit_count(bc1),
    .frame_error(fe1), .overrun(or1)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  bit         model_full = 1'b0;
  bit         exp_overrun = 1'b0;
  bit         exp_ferr = 1'b0;
  bit         exp_busy = 1'b0;
  int         exp_bc = 0;
  bit         checking = 1'b0;
  int         rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 high only on completing strobe
  int         clr_pct = 0;
  bit         in_frame = 1'b0;
  int         nbits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
    return r;
  endfunction

  // Monitor: compares every cycle against the model; pops on each handshake
  always @(negedge CLK) begin
    if (checking) begin
      check("valid0", 32'(ov0), 32'(model_full));
      check("valid1", 32'(ov1), 32'(model_full));
      check("overrun0", 32'(or0), 32'(exp_overrun));
      check("overrun1", 32'(or1), 32'(exp_overrun));
      check("ferr0", 32'(fe0), 32'(exp_ferr));
      check("ferr1", 32'(fe1), 32'(exp_ferr));
      check("busy0", 32'(bz0), 32'(exp_busy));
      check("bitcnt0", 32'(bc0), 32'(exp_bc));
      check("bitcnt1", 32'(bc1), 32'(exp_bc));
      if (model_full) begin
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
          total++;
          bad++;
          $display("FAIL scoreboard_empty actual=empty required=word at %0t", $time);
        end else begin
          check("data0", 32'(po0), 32'(exp_q0[0]));
          check("data1", 32'(po1), 32'(exp_q1[0]));
          if (out_ready) begin
            void'(exp_q0.pop_front());
            void'(exp_q1.pop_front());
          end
        end
      end
    end
  end

  // One clock of stimulus, then update the model with what that edge must do
  task automatic step(input bit fs, input bit st, input bit sb, input bit cmpl,
                      input bit ferr, input int bc_after, input bit busy_after,
                      input logic [7:0] tx);
    bit rdy, clr, xfer, set_ov;
    rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1) ||
          (rdy_mode == 3 && cmpl);
    clr = ($urandom_range(0, 99) < clr_pct);
    frame_start   = fs;
    bit_strobe    = st;
    serial_input  = sb;
    out_ready     = rdy;
    clear_overrun = clr;
    @(posedge CLK);
    #1;
    xfer   = model_full && rdy;
    set_ov = cmpl && model_full && !xfer;
    if (cmpl && !set_ov) begin
      exp_q0.push_back(tx);
      exp_q1.push_back(rev8(tx));
      model_full = 1'b1;
    end else if (xfer) begin
      model_full = 1'b0;
    end
    if (set_ov) exp_overrun = 1'b1;
    else if (clr) exp_overrun = 1'b0;
    exp_ferr = ferr;
    exp_bc   = bc_after;
    exp_busy = busy_after;
  endtask

  task automatic idle_cycles(input int n, input bit stray);
    bit st;
    for (int i = 0; i < n; i++) begin
      st = stray && ($urandom_range(0, 3) == 0);
      step(1'b0, st, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 0, 1'b0, 8'h00);
    end
  endtask

  task automatic start_frame();
    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, in_frame, 0, 1'b1, 8'h00);
    in_frame = 1'b1;
    nbits    = 0;
  endtask

  // tx[i] is the i-th bit on the wire
  task automatic send_bits(input logic [7:0] tx, input int k);
    int gap;
    for (int i = 0; i < k; i++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, nbits, 1'b1, 8'h00);
      nbits++;
      if (nbits == 8) begin
        step(1'b0, 1'b1, tx[i], 1'b1, 1'b0, 0, 1'b0, tx);
        in_frame = 1'b0;
        nbits    = 0;
      end else begin
        step(1'b0, 1'b1, tx[i], 1'b0, 1'b0, nbits, 1'b1, 8'h00);
      end
    end
  endtask

  task automatic timeout_gap();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00);
      else        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nbits, 1'b1, 8'h00);
    end
    in_frame = 1'b0;
    nbits    = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1; frame_start = 1'b0; bit_strobe = 1'b0; out_ready = 1'b0; clear_overrun = 1'b0;
    @(posedge CLK);
    #1;
    exp_q0.delete();
    exp_q1.delete();
    model_full = 1'b0; exp_overrun = 1'b0; exp_ferr = 1'b0; exp_busy = 1'b0; exp_bc = 0;
    in_frame = 1'b0; nbits = 0;
    @(posedge CLK);
    #1;
    check("rst_data0", 32'(po0), 32'h0);
    check("rst_data1", 32'(po1), 32'h0);
    check("rst_busy1", 32'(bz1), 32'h0);
    RST = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tx;
    int sel;
    serial_input = 1'b0;
    do_reset();
    checking = 1'b1;

    // LSB-first 1,0,1,0,0,1,0,1 -> A5 on both instances; held while out_ready low
    rdy_mode = 0;
    start_frame();
    send_bits(8'hA5, 8);
    check("a5_lsb", 32'(po0), 32'hA5);
    check("a5_msb", 32'(po1), 32'hA5);
    idle_cycles(3, 1'b1);
    rdy_mode = 1;
    idle_cycles(2, 1'b0);

    // Stream 0,0,1,1,0,1,0,1 -> 35 MSB-first, AC LSB-first
    rdy_mode = 0;
    start_frame();
    send_bits(8'hAC, 8);
    check("s35_msb", 32'(po1), 32'h35);
    check("s35_lsb", 32'(po0), 32'hAC);
    rdy_mode = 1;
    idle_cycles(2, 1'b0);

    // Overrun: second word dropped, then cleared
    rdy_mode = 0;
    start_frame(); send_bits(8'h3C, 8);
    start_frame(); send_bits(8'hC3, 8);
    check("ovr_keep", 32'(po0), 32'h3C);
    check("ovr_set", 32'(or0), 32'h1);
    clr_pct = 100;
    idle_cycles(1, 1'b0);
    clr_pct = 0;
    check("ovr_clr", 32'(or0), 32'h0);
    rdy_mode = 1;
    idle_cycles(2, 1'b0);

    // Completion coinciding with a transfer loads the new word, no overrun
    rdy_mode = 0;
    start_frame(); send_bits(8'h3C, 8);
    rdy_mode = 3;
    start_frame(); send_bits(8'hC3, 8);
    check("coinc_data", 32'(po0), 32'hC3);
    check("coinc_valid", 32'(ov0), 32'h1);
    check("coinc_ovr", 32'(or0), 32'h0);
    rdy_mode = 1;
    idle_cycles(2, 1'b0);

    // Reset mid-frame, then a clean frame
    start_frame(); send_bits(8'hFF, 3);
    do_reset();
    check("rst_busy", 32'(bz0), 32'h0);
    start_frame(); send_bits(8'h5A, 8);
    idle_cycles(2, 1'b0);

    // Timeout after 3 bits
    start_frame(); send_bits(8'h0F, 3);
    timeout_gap();
    check("to_ferr", 32'(fe0), 32'h1);
    check("to_busy", 32'(bz0), 32'h0);
    check("to_valid", 32'(ov0), 32'h0);
    idle_cycles(2, 1'b1);

    // Restart after 5 bits, then a full word
    start_frame(); send_bits(8'hE7, 5);
    start_frame();
    check("rs_ferr", 32'(fe0), 32'h1);
    check("rs_cnt", 32'(bc0), 32'h0);
    send_bits(8'h96, 8);
    check("rs_data0", 32'(po0), 32'h96);
    idle_cycles(2, 1'b0);

    // Randomized traffic with random backpressure, clears, restarts and timeouts
    rdy_mode = 2;
    clr_pct  = 5;
    for (int f = 0; f < 300; f++) begin
      idle_cycles($urandom_range(0, 3), 1'b1);
      tx = 8'($urandom);
      start_frame();
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        send_bits(tx, $urandom_range(1, 7));
        start_frame();
        tx = 8'($urandom);
        send_bits(tx, 8);
      end else if (sel == 1) begin
        send_bits(tx, $urandom_range(0, 7));
        timeout_gap();
      end else begin
        send_bits(tx, 8);
      end
    end
    rdy_mode = 1;
    clr_pct  = 0;
    idle_cycles(3, 1'b0);
    check("final_valid", 32'(ov0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
